eisenberg_mutex_n: RTL and testbench

EISENBERG_MUTEX_N -- requirements
Module: eisenberg_mutex_n

---
 rtl/eisenberg_mutex_n.sv | 192 +++++++++++++++++++
 tb/tb_eisenberg_mutex_n.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/eisenberg_mutex_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : eisenberg_mutex_n                                                |
// | Purpose : N-process Eisenberg-McGuire mutex, one process stepped per edge. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module eisenberg_mutex_n #(
  parameter int NPROC = 3,
  parameter int SELW  = 2,
  parameter int WAITW = 4,
  parameter int RR    = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SELW-1:0]  select,
  input  logic             pause,
  output logic [SELW-1:0]  sel_q,
  output logic [NPROC-1:0] in_cs,
  output logic [SELW-1:0]  turn,
  output logic             mutex_err,
  output logic [NPROC-1:0] starve
);

  typedef enum logic [3:0] {
    L1  = 4'd0,  L2  = 4'd1,  L3  = 4'd2,  L4  = 4'd3,
    L5  = 4'd4,  L6  = 4'd5,  L7  = 4'd6,  L8  = 4'd7,
    L9  = 4'd8,  L10 = 4'd9,  L11 = 4'd10, L12 = 4'd11,
    L13 = 4'd12, L14 = 4'd13, L15 = 4'd14, L16 = 4'd15
  } pc_t;

  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_WAITING = 2'd1,
    F_ACTIVE  = 2'd2
  } flag_t;

  localparam logic [SELW:0]    c_nproc    = (SELW+1)'(NPROC);
  localparam logic [SELW:0]    c_last_j   = (SELW+1)'(NPROC-1);
  localparam logic [SELW-1:0]  c_last_sel = (SELW)'(NPROC-1);
  localparam logic [WAITW-1:0] c_wait_max = '1;

  pc_t             r_pc   [NPROC];
  flag_t           r_flag [NPROC];
  logic [SELW:0]   r_j    [NPROC];
  logic [WAITW-1:0] r_wait [NPROC];
  logic [SELW-1:0] r_turn;
  logic [SELW-1:0] r_sel_q;
  logic [SELW-1:0] r_rr_ptr;
  logic            r_mutex_err;

  logic [SELW-1:0]  w_sel;
  pc_t              w_cur_pc;
  pc_t              w_pc_nx;
  flag_t            w_cur_flag;
  flag_t            w_flag_nx;
  flag_t            w_flag_j;
  flag_t            w_flag_turn;
  logic [SELW:0]    w_cur_j;
  logic [SELW:0]    w_j_nx;
  logic [SELW-1:0]  w_turn_nx;
  logic [NPROC-1:0] w_hit;
  logic [NPROC-1:0] w_cs_nx;
  logic [NPROC-1:0] w_busy_now;
  logic [NPROC-1:0] w_busy_next;
  logic             w_multi;

  function automatic logic [SELW:0] inc_mod(input logic [SELW:0] x);
    return (x >= c_last_j) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    if (RR != 0) begin
      w_sel = r_rr_ptr;
    end else if ({1'b0, select} >= c_nproc) begin
      w_sel = '0;
    end else begin
      w_sel = select;
    end
  end

  // Operand fetch for the stepped process; out-of-range indices read as idle.
  always_comb begin
    w_cur_pc    = L1;
    w_cur_flag  = F_IDLE;
    w_cur_j     = '0;
    w_flag_j    = F_IDLE;
    w_flag_turn = F_IDLE;
    for (int i = 0; i < NPROC; i++) begin
      if (w_sel == (SELW)'(i)) begin
        w_cur_pc   = r_pc[i];
        w_cur_flag = r_flag[i];
        w_cur_j    = r_j[i];
      end
    end
    for (int i = 0; i < NPROC; i++) begin
      if (w_cur_j == (SELW+1)'(i)) w_flag_j = r_flag[i];
      if (r_turn == (SELW)'(i))    w_flag_turn = r_flag[i];
    end
  end

  always_comb begin
    w_pc_nx   = w_cur_pc;
    w_flag_nx = w_cur_flag;
    w_j_nx    = w_cur_j;
    w_turn_nx = r_turn;
    case (w_cur_pc)
      L1:  begin w_flag_nx = F_WAITING; w_pc_nx = L2; end
      L2:  begin w_j_nx = {1'b0, r_turn}; w_pc_nx = L3; end
      L3:  w_pc_nx = (w_cur_j != {1'b0, w_sel}) ? L4 : L7;
      L4:  w_pc_nx = (w_flag_j != F_IDLE) ? L5 : L6;
      L5:  begin w_j_nx = {1'b0, r_turn}; w_pc_nx = L3; end
      L6:  begin w_j_nx = inc_mod(w_cur_j); w_pc_nx = L3; end
      L7:  begin w_flag_nx = F_ACTIVE; w_pc_nx = L8; end
      L8:  begin w_j_nx = '0; w_pc_nx = L9; end
      L9: begin
        if ((w_cur_j < c_nproc) &&
            ((w_cur_j == {1'b0, w_sel}) || (w_flag_j != F_ACTIVE))) begin
          w_j_nx = w_cur_j + 1'b1;
        end else begin
          w_pc_nx = L10;
        end
      end
      L10: begin
        if ((w_cur_j >= c_nproc) && ((r_turn == w_sel) || (w_flag_turn == F_IDLE)))
          w_pc_nx = L11;
        else
          w_pc_nx = L1;
      end
      L11: begin w_turn_nx = w_sel; w_pc_nx = L12; end
      L12: w_pc_nx = pause ? L12 : L13;
      L13: begin w_j_nx = inc_mod({1'b0, r_turn}); w_pc_nx = L14; end
      L14: begin
        if (w_flag_j == F_IDLE) w_j_nx = inc_mod(w_cur_j);
        else                    w_pc_nx = L15;
      end
      L15: begin w_turn_nx = w_cur_j[SELW-1:0]; w_pc_nx = L16; end
      L16: begin w_flag_nx = F_IDLE; w_pc_nx = pause ? L16 : L1; end
      default: w_pc_nx = L1;
    endcase
  end

  for (genvar g = 0; g < NPROC; g++) begin : g_proc
    pc_t w_pc_next;
    assign w_hit[g]       = (w_sel == (SELW)'(g));
    assign w_pc_next      = w_hit[g] ? w_pc_nx : r_pc[g];
    assign w_cs_nx[g]     = (w_pc_next == L12);
    assign w_busy_now[g]  = (r_pc[g] >= L2) && (r_pc[g] <= L11);
    assign w_busy_next[g] = (w_pc_next >= L2) && (w_pc_next <= L11);
    assign in_cs[g]       = (r_pc[g] == L12);
    assign starve[g]      = (r_wait[g] == c_wait_max);
  end

  assign w_multi = ($countones(w_cs_nx) > 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPROC; i++) begin
        r_pc[i]   <= L1;
        r_flag[i] <= F_IDLE;
        r_j[i]    <= '0;
        r_wait[i] <= '0;
      end
      r_turn      <= '0;
      r_sel_q     <= '0;
      r_rr_ptr    <= '0;
      r_mutex_err <= 1'b0;
    end else begin
      for (int i = 0; i < NPROC; i++) begin
        if (w_hit[i]) begin
          r_pc[i]   <= w_pc_nx;
          r_flag[i] <= w_flag_nx;
          r_j[i]    <= w_j_nx;
        end
        // Waiting time accrues on every edge, scheduled or not.
        if (!w_busy_next[i])
          r_wait[i] <= '0;
        else if (w_busy_now[i] && (r_wait[i] != c_wait_max))
          r_wait[i] <= r_wait[i] + 1'b1;
      end
      r_turn   <= w_turn_nx;
      r_sel_q  <= w_sel;
      r_rr_ptr <= (r_rr_ptr == c_last_sel) ? '0 : r_rr_ptr + 1'b1;
      if (w_multi) r_mutex_err <= 1'b1;
    end
  end

  assign sel_q     = r_sel_q;
  assign turn      = r_turn;
  assign mutex_err = r_mutex_err;

endmodule
`default_nettype wire

// File: tb/tb_eisenberg_mutex_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_eisenberg_mutex_n                                             |
// | Purpose : Directed and random checks of eisenberg_mutex_n (NPROC=3).       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_eisenberg_mutex_n;

  localparam int NPROC = 3;
  localparam int SELW  = 2;
  localparam int WAITW = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [SELW-1:0]  select;
  logic             pause;
  logic [SELW-1:0]  sel_q, turn, rr_sel_q, rr_turn;
  logic [NPROC-1:0] in_cs, starve, rr_in_cs, rr_starve;
  logic             mutex_err, rr_mutex_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NPROC-1:0] cs;
    logic [SELW-1:0]  sel;
    logic [SELW-1:0]  rr_sel;
  } exp_t;
  exp_t sb[$];
  logic [SELW-1:0] rr_exp;

  always #5 clock = ~clock;

  eisenberg_mutex_n #(.NPROC(NPROC), .SELW(SELW), .WAITW(WAITW), .RR(0)) u_dut (
    .clock(clock), .reset(reset), .select(select), .pause(pause),
    .sel_q(sel_q), .in_cs(in_cs), .turn(turn), .mutex_err(mutex_err), .starve(starve)
  );

  eisenberg_mutex_n #(.NPROC(NPROC), .SELW(SELW), .WAITW(WAITW), .RR(1)) u_rr (
    .clock(clock), .reset(reset), .select(select), .pause(pause),
    .sel_q(rr_sel_q), .in_cs(rr_in_cs), .turn(rr_turn), .mutex_err(rr_mutex_err),
    .starve(rr_starve)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [SELW-1:0] s, input logic p,
                      input logic [NPROC-1:0] e_cs, input logic [SELW-1:0] e_sel);
    exp_t e;
    select   = s;
    pause    = p;
    e.cs     = e_cs;
    e.sel    = e_sel;
    e.rr_sel = rr_exp;
    sb.push_back(e);
    rr_exp = (rr_exp == 2'd2) ? 2'd0 : rr_exp + 2'd1;
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("in_cs", 32'(in_cs), 32'(e.cs));
    chk("sel_q", 32'(sel_q), 32'(e.sel));
    chk("rr_sel_q", 32'(rr_sel_q), 32'(e.rr_sel));
  endtask

  // Reset is raised between edges so its asynchronous effect is observed at once.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_in_cs", 32'(in_cs), 32'd0);
    chk("rst_turn", 32'(turn), 32'd0);
    chk("rst_mutex_err", 32'(mutex_err), 32'd0);
    chk("rst_starve", 32'(starve), 32'd0);
    chk("rst_sel_q", 32'(sel_q), 32'd0);
    chk("rst_rr_sel_q", 32'(rr_sel_q), 32'd0);
    chk("rst_rr_in_cs", 32'(rr_in_cs), 32'd0);
    rr_exp = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    select = '0;
    pause  = 1'b0;
    rr_exp = '0;
    do_reset();

    // Process 0 alone: 11 edges to the critical section.
    for (int k = 1; k <= 11; k++) step(2'd0, 1'b0, (k == 11) ? 3'b001 : 3'b000, 2'd0);
    chk("solo_turn", 32'(turn), 32'd0);
    for (int k = 0; k < 5; k++) step(2'd0, 1'b1, 3'b001, 2'd0);
    // Exit path L12,L13,L14(x3),L15,L16 returns to L1 after 7 edges.
    for (int k = 0; k < 7; k++) step(2'd0, 1'b0, 3'b000, 2'd0);
    chk("exit_turn", 32'(turn), 32'd0);

    // Process 1 can enter only if process 0 really released its flag.
    for (int k = 1; k <= 14; k++) step(2'd1, 1'b0, (k == 14) ? 3'b010 : 3'b000, 2'd1);
    chk("p1_turn", 32'(turn), 32'd1);
    do_reset();

    // Process 2 from turn=0 scans past 0 and 1: 17 edges, then turn=2.
    for (int k = 1; k <= 17; k++) step(2'd2, 1'b0, (k == 17) ? 3'b100 : 3'b000, 2'd2);
    chk("p2_turn", 32'(turn), 32'd2);
    do_reset();

    step(2'd3, 1'b0, 3'b000, 2'd0);
    step(2'd2, 1'b0, 3'b000, 2'd2);
    do_reset();

    // Process 1 parked in L2 while only process 0 is scheduled.
    step(2'd1, 1'b0, 3'b000, 2'd1);
    for (int k = 1; k <= 15; k++) begin
      step(2'd0, 1'b0, (k == 11) ? 3'b001 : 3'b000, 2'd0);
      chk("starve1_edge", 32'(starve[1]), (k == 15) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 10; k++) begin
      step(2'd0, 1'b0, 3'b000, 2'd0);
      chk("starve1_hold", 32'(starve[1]), 32'd1);
    end
    do_reset();

    for (int k = 0; k < 20000; k++) begin
      select = SELW'($urandom_range(0, 3));
      pause  = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      chk("rand_onehot", 32'($onehot0(in_cs)), 32'd1);
      chk("rand_mutex_err", 32'(mutex_err), 32'd0);
      chk("rand_rr_onehot", 32'($onehot0(rr_in_cs)), 32'd1);
      chk("rand_rr_mutex_err", 32'(rr_mutex_err), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
